// File: rtl/pe_acc_drain_pkg.sv
// Shared types and constants for the PE accumulator / drain back end.
package pe_acc_drain_pkg;

  // Accumulator width; must match the adder tree sum width.
  localparam int ACC_W = 66;
  // Width of the dot-product length field and of the beat counter.
  localparam int LEN_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic             sign;
    logic [ACC_W-1:0] mag;
  } result_t;

endpackage

// File: rtl/pe_acc_drain_if.sv
// Bundle of control, tree feedback and result handshake signals between the
// PE adder tree environment (master) and the accumulator / drain block (slave).
interface pe_acc_drain_if;
  import pe_acc_drain_pkg::*;

  logic             start;
  logic [LEN_W-1:0] len;
  logic             tree_valid;
  logic             tree_ready;
  logic [ACC_W-1:0] tree_sum;
  logic [ACC_W-1:0] acc_out;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_mag;
  logic             out_sign;
  logic             busy;

  modport master (
    output start, len, tree_valid, tree_sum, out_ready,
    input  tree_ready, acc_out, out_valid, out_mag, out_sign, busy
  );

  modport slave (
    input  start, len, tree_valid, tree_sum, out_ready,
    output tree_ready, acc_out, out_valid, out_mag, out_sign, busy
  );

endinterface

// File: rtl/pe_sign_mag.sv
// Combinational two's-complement to sign-magnitude converter. Negative
// values are negated by keeping every bit up to and including the lowest 1
// and inverting all bits above it (prefix-OR complement), which avoids a
// full-width incrementer. The most negative value maps onto itself, which
// is the correct unsigned magnitude.
module pe_sign_mag
  import pe_acc_drain_pkg::*;
(
  input  logic [ACC_W-1:0] value,
  output result_t          result
);

  // Walk upward from the LSB, flipping a bit once any lower bit was 1.
  always_comb begin
    logic seen;
    logic neg;
    seen        = 1'b0;
    neg         = value[ACC_W-1];
    result.sign = neg;
    result.mag  = '0;
    for (int i = 0; i < ACC_W; i++) begin
      result.mag[i] = neg ? (value[i] ^ seen) : value[i];
      seen          = seen | value[i];
    end
  end

endmodule

// File: rtl/pe_acc_drain.sv
// Sequential back end of the PE adder tree: holds the running accumulator
// fed back to the tree, counts accepted tree beats for one dot product and
// hands the final value downstream in sign-magnitude form.
module pe_acc_drain
  import pe_acc_drain_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  pe_acc_drain_if.slave  bus
);

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] count;
  logic [LEN_W-1:0] len_q;
  logic [ACC_W-1:0] acc_q;
  result_t          res_q;
  result_t          conv;
  logic             last_beat;

  // The accepted beat is the final one when count has reached len-1; the
  // compare is never evaluated with len_q==0 because that case skips ACCUM.
  assign last_beat = bus.tree_valid && (count == (len_q - LEN_W'(1)));

  pe_sign_mag u_sign_mag (
    .value  (bus.tree_sum),
    .result (conv)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = (bus.len == '0) ? DRAIN : ACCUM;
      end
      ACCUM: begin
        if (last_beat) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulator, beat counter, latched length and captured result.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      count <= '0;
      len_q <= '0;
      res_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            len_q <= bus.len;
            acc_q <= '0;
            count <= '0;
            if (bus.len == '0) res_q <= '0;
          end
        end
        ACCUM: begin
          if (bus.tree_valid) begin
            if (last_beat) begin
              res_q <= conv;
              acc_q <= '0;
              count <= '0;
            end else begin
              acc_q <= bus.tree_sum;
              count <= count + LEN_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    bus.tree_ready = (state == ACCUM);
    bus.out_valid  = (state == DRAIN);
    bus.busy       = (state != IDLE);
  end

  assign bus.acc_out  = acc_q;
  assign bus.out_mag  = res_q.mag;
  assign bus.out_sign = res_q.sign;

endmodule

// File: tb/tb_pe_acc_drain.sv
// Directed self-checking bench for pe_acc_drain. The adder tree is modelled
// as tree_sum = acc_out + term; expected values are hand-computed constants.
module tb_pe_acc_drain;
  import pe_acc_drain_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic [ACC_W-1:0] term;
  int               total = 0;
  int               bad   = 0;

  localparam logic [ACC_W-1:0] NEG30   = -66'd30;
  localparam logic [ACC_W-1:0] NEG1    = {ACC_W{1'b1}};
  localparam logic [ACC_W-1:0] MOSTNEG = {1'b1, {(ACC_W-1){1'b0}}};

  pe_acc_drain_if bus ();

  assign bus.tree_sum = bus.acc_out + term;

  pe_acc_drain dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Count one comparison and report it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [ACC_W-1:0] got,
                             input logic [ACC_W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then let the clock edge act and settle.
  task automatic applyStimulus(input logic s, input logic [LEN_W-1:0] l,
                               input logic tv, input logic [ACC_W-1:0] t,
                               input logic rdy);
    bus.start      = s;
    bus.len        = l;
    bus.tree_valid = tv;
    term           = t;
    bus.out_ready  = rdy;
    @(posedge clk);
    #1;
  endtask

  // Gapped beat pattern for the len=4 case; expected acc_out after each cycle.
  logic tv_pat  [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  int   term_pat[7] = '{3, 99, 99, 4, 5, 99, 6};
  int   acc_pat [7] = '{3, 3, 3, 7, 12, 12, 0};
  logic vld_pat [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  // Main directed sequence.
  initial begin
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.len        = '0;
    bus.tree_valid = 1'b0;
    bus.out_ready  = 1'b0;
    term           = '0;
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("rst_tree_ready", bus.tree_ready, 0);
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_acc", bus.acc_out, 0);
    checkOutput("rst_mag", bus.out_mag, 0);
    checkOutput("rst_sign", bus.out_sign, 0);
    rst = 1'b0;

    // len=3: sums 5, 12, 20.
    applyStimulus(1, 3, 0, 0, 0);
    checkOutput("t1_tree_ready", bus.tree_ready, 1);
    checkOutput("t1_busy", bus.busy, 1);
    checkOutput("t1_acc0", bus.acc_out, 0);
    applyStimulus(0, 0, 1, 5, 0);
    checkOutput("t1_acc1", bus.acc_out, 5);
    applyStimulus(0, 0, 1, 7, 0);
    checkOutput("t1_acc2", bus.acc_out, 12);
    checkOutput("t1_valid_early", bus.out_valid, 0);
    applyStimulus(0, 0, 1, 8, 0);
    checkOutput("t1_acc_clr", bus.acc_out, 0);
    checkOutput("t1_valid", bus.out_valid, 1);
    checkOutput("t1_tree_ready_off", bus.tree_ready, 0);
    checkOutput("t1_mag", bus.out_mag, 20);
    checkOutput("t1_sign", bus.out_sign, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t1_done_valid", bus.out_valid, 0);
    checkOutput("t1_done_busy", bus.busy, 0);

    // len=2: 7 then -30 gives -23; stall five cycles before accepting.
    applyStimulus(1, 2, 0, 0, 0);
    applyStimulus(0, 0, 1, 7, 0);
    checkOutput("t2_acc1", bus.acc_out, 7);
    applyStimulus(0, 0, 1, NEG30, 0);
    checkOutput("t2_valid", bus.out_valid, 1);
    checkOutput("t2_sign", bus.out_sign, 1);
    checkOutput("t2_mag", bus.out_mag, 23);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("t2_stall_valid", bus.out_valid, 1);
      checkOutput("t2_stall_mag", bus.out_mag, 23);
      checkOutput("t2_stall_sign", bus.out_sign, 1);
      checkOutput("t2_stall_busy", bus.busy, 1);
    end
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t2_done_busy", bus.busy, 0);
    checkOutput("t2_done_valid", bus.out_valid, 0);

    // len=0: immediate zero result; start during the handshake is ignored.
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("t3_valid", bus.out_valid, 1);
    checkOutput("t3_mag", bus.out_mag, 0);
    checkOutput("t3_sign", bus.out_sign, 0);
    checkOutput("t3_tree_ready", bus.tree_ready, 0);
    applyStimulus(1, 5, 0, 0, 1);
    checkOutput("t3_done_busy", bus.busy, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t3_idle_busy", bus.busy, 0);
    checkOutput("t3_idle_tree_ready", bus.tree_ready, 0);

    // len=4 with gaps; a start pulse in ACCUM must not restart.
    applyStimulus(1, 4, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus((i == 2), 1, tv_pat[i], ACC_W'(term_pat[i]), 0);
      checkOutput("t4_acc", bus.acc_out, ACC_W'(acc_pat[i]));
      checkOutput("t4_valid", bus.out_valid, vld_pat[i]);
    end
    checkOutput("t4_mag", bus.out_mag, 18);
    checkOutput("t4_sign", bus.out_sign, 0);
    applyStimulus(0, 0, 0, 0, 1);

    // Most negative value and -1.
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, MOSTNEG, 0);
    checkOutput("t5_mn_sign", bus.out_sign, 1);
    checkOutput("t5_mn_mag", bus.out_mag, MOSTNEG);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, NEG1, 0);
    checkOutput("t5_m1_sign", bus.out_sign, 1);
    checkOutput("t5_m1_mag", bus.out_mag, 1);
    applyStimulus(0, 0, 0, 0, 1);

    // Reset mid-ACCUM, then an independent len=1 run.
    applyStimulus(1, 5, 0, 0, 0);
    applyStimulus(0, 0, 1, 9, 0);
    applyStimulus(0, 0, 1, 11, 0);
    checkOutput("t6_acc_pre", bus.acc_out, 20);
    rst = 1'b1;
    applyStimulus(0, 0, 1, 13, 0);
    rst = 1'b0;
    checkOutput("t6_rst_busy", bus.busy, 0);
    checkOutput("t6_rst_acc", bus.acc_out, 0);
    checkOutput("t6_rst_valid", bus.out_valid, 0);
    checkOutput("t6_rst_tree_ready", bus.tree_ready, 0);
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("t6_acc_start", bus.acc_out, 0);
    applyStimulus(0, 0, 1, 42, 0);
    checkOutput("t6_valid", bus.out_valid, 1);
    checkOutput("t6_mag", bus.out_mag, 42);
    checkOutput("t6_sign", bus.out_sign, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t6_done_busy", bus.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
